// File: rtl/tagged_value_buffer.sv
// Tagged immediate/PC value store: written at dispatch, read at issue, squashed by branch tag.
// Define VB_BYPASS_EN to forward same-cycle accepted writes to the read ports.
module tagged_value_buffer #(
  parameter int unsigned BUFFER_NUM = 32,
  parameter int unsigned BUFFER_SEL = 5,
  parameter int unsigned DATA_DEPTH = 32,
  parameter int unsigned WR_PORTS   = 2,
  parameter int unsigned RD_PORTS   = 3,
  parameter int unsigned TAG_NUM    = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           stall,
  input  logic [WR_PORTS-1:0]            wr_valid,
  input  logic [WR_PORTS*BUFFER_SEL-1:0] wr_ptr,
  input  logic [WR_PORTS*DATA_DEPTH-1:0] wr_value,
  input  logic [WR_PORTS*TAG_NUM-1:0]    wr_tagmask,
  input  logic [RD_PORTS-1:0]            rel_valid,
  input  logic [RD_PORTS*BUFFER_SEL-1:0] rel_ptr,
  input  logic [RD_PORTS*BUFFER_SEL-1:0] rd_ptr,
  output logic [RD_PORTS*DATA_DEPTH-1:0] rd_value,
  output logic [RD_PORTS-1:0]            rd_hit,
  input  logic                           br_kill,
  input  logic [TAG_NUM-1:0]             br_kill_tag,
  input  logic                           br_ok,
  input  logic [TAG_NUM-1:0]             br_ok_tag,
  output logic [BUFFER_SEL:0]            occupancy
);

  localparam int unsigned OCC_W = BUFFER_SEL + 1;

  logic [BUFFER_NUM-1:0]          valid_q;
  logic [BUFFER_NUM-1:0]          valid_n;
  logic [TAG_NUM-1:0]             mask_q [BUFFER_NUM];
  logic [TAG_NUM-1:0]             mask_n [BUFFER_NUM];
  logic [DATA_DEPTH-1:0]          data_q [BUFFER_NUM];
  logic [WR_PORTS-1:0]            wr_accept;
  logic [OCC_W-1:0]               occ_n;
  logic [RD_PORTS*DATA_DEPTH-1:0] rd_value_n;
  logic [RD_PORTS-1:0]            rd_hit_n;

  // A write is dropped when stalled or when it depends on the branch being killed
  always_comb begin
    wr_accept = '0;
    for (int unsigned k = 0; k < WR_PORTS; k++) begin
      wr_accept[k] = wr_valid[k] && !stall &&
                     !(br_kill && (|(wr_tagmask[k*TAG_NUM +: TAG_NUM] & br_kill_tag)));
    end
  end

  // Next valid/mask state: kill and release first, writes override, confirm clears last
  always_comb begin
    valid_n = valid_q;
    mask_n  = mask_q;
    occ_n   = '0;
    if (br_kill) begin
      for (int unsigned i = 0; i < BUFFER_NUM; i++) begin
        if (|(mask_q[i] & br_kill_tag)) valid_n[i] = 1'b0;
      end
    end
    for (int unsigned j = 0; j < RD_PORTS; j++) begin
      if (rel_valid[j]) valid_n[rel_ptr[j*BUFFER_SEL +: BUFFER_SEL]] = 1'b0;
    end
    for (int unsigned k = 0; k < WR_PORTS; k++) begin
      if (wr_accept[k]) begin
        valid_n[wr_ptr[k*BUFFER_SEL +: BUFFER_SEL]] = 1'b1;
        mask_n[wr_ptr[k*BUFFER_SEL +: BUFFER_SEL]]  = wr_tagmask[k*TAG_NUM +: TAG_NUM];
      end
    end
    if (br_ok) begin
      for (int unsigned i = 0; i < BUFFER_NUM; i++) begin
        mask_n[i] = mask_n[i] & ~br_ok_tag;
      end
    end
    for (int unsigned i = 0; i < BUFFER_NUM; i++) begin
      occ_n = occ_n + OCC_W'(valid_n[i]);
    end
  end

  // Read ports see the pre-edge contents unless bypass forwards an accepted write
  always_comb begin
    rd_value_n = '0;
    rd_hit_n   = '0;
    for (int unsigned j = 0; j < RD_PORTS; j++) begin
      rd_value_n[j*DATA_DEPTH +: DATA_DEPTH] = data_q[rd_ptr[j*BUFFER_SEL +: BUFFER_SEL]];
      rd_hit_n[j] = valid_q[rd_ptr[j*BUFFER_SEL +: BUFFER_SEL]];
`ifdef VB_BYPASS_EN
      for (int unsigned k = 0; k < WR_PORTS; k++) begin
        if (wr_accept[k] &&
            (wr_ptr[k*BUFFER_SEL +: BUFFER_SEL] == rd_ptr[j*BUFFER_SEL +: BUFFER_SEL])) begin
          rd_value_n[j*DATA_DEPTH +: DATA_DEPTH] = wr_value[k*DATA_DEPTH +: DATA_DEPTH];
          rd_hit_n[j] = 1'b1;
        end
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q   <= '0;
      for (int unsigned i = 0; i < BUFFER_NUM; i++) mask_q[i] <= '0;
      rd_value  <= '0;
      rd_hit    <= '0;
      occupancy <= '0;
    end else begin
      valid_q   <= valid_n;
      mask_q    <= mask_n;
      rd_value  <= rd_value_n;
      rd_hit    <= rd_hit_n;
      occupancy <= occ_n;
    end
  end

  // Payload storage is never cleared; ascending port order lets the highest port win
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < WR_PORTS; k++) begin
        if (wr_accept[k])
          data_q[wr_ptr[k*BUFFER_SEL +: BUFFER_SEL]] <= wr_value[k*DATA_DEPTH +: DATA_DEPTH];
      end
    end
  end

endmodule

// File: tb/tb_tagged_value_buffer.sv
// Directed self-checking bench for tagged_value_buffer with hand-computed expectations.
module tb_tagged_value_buffer;

  localparam int unsigned BN = 32;
  localparam int unsigned BS = 5;
  localparam int unsigned DD = 32;
  localparam int unsigned WP = 2;
  localparam int unsigned RP = 3;
  localparam int unsigned TN = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             stall;
  logic [WP-1:0]    wr_valid;
  logic [WP*BS-1:0] wr_ptr;
  logic [WP*DD-1:0] wr_value;
  logic [WP*TN-1:0] wr_tagmask;
  logic [RP-1:0]    rel_valid;
  logic [RP*BS-1:0] rel_ptr;
  logic [RP*BS-1:0] rd_ptr;
  logic [RP*DD-1:0] rd_value;
  logic [RP-1:0]    rd_hit;
  logic             br_kill;
  logic [TN-1:0]    br_kill_tag;
  logic             br_ok;
  logic [TN-1:0]    br_ok_tag;
  logic [BS:0]      occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  tagged_value_buffer #(
    .BUFFER_NUM(BN), .BUFFER_SEL(BS), .DATA_DEPTH(DD),
    .WR_PORTS(WP), .RD_PORTS(RP), .TAG_NUM(TN)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .wr_valid(wr_valid), .wr_ptr(wr_ptr), .wr_value(wr_value), .wr_tagmask(wr_tagmask),
    .rel_valid(rel_valid), .rel_ptr(rel_ptr),
    .rd_ptr(rd_ptr), .rd_value(rd_value), .rd_hit(rd_hit),
    .br_kill(br_kill), .br_kill_tag(br_kill_tag),
    .br_ok(br_ok), .br_ok_tag(br_ok_tag),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    stall = 1'b0; wr_valid = '0; wr_ptr = '0; wr_value = '0; wr_tagmask = '0;
    rel_valid = '0; rel_ptr = '0; rd_ptr = '0;
    br_kill = 1'b0; br_kill_tag = '0; br_ok = 1'b0; br_ok_tag = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input int k, input int ptr, input logic [DD-1:0] v, input logic [TN-1:0] m);
    wr_valid[k] = 1'b1;
    wr_ptr[k*BS +: BS] = BS'(ptr);
    wr_value[k*DD +: DD] = v;
    wr_tagmask[k*TN +: TN] = m;
  endtask

  task automatic set_rd(input int j, input int ptr);
    rd_ptr[j*BS +: BS] = BS'(ptr);
  endtask

  task automatic set_rel(input int j, input int ptr);
    rel_valid[j] = 1'b1;
    rel_ptr[j*BS +: BS] = BS'(ptr);
  endtask

  function automatic logic [DD-1:0] rv(input int j);
    return rd_value[j*DD +: DD];
  endfunction

  initial begin
    idle();
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    check_eq("reset_occ", 64'(occupancy), 64'd0);
    check_eq("reset_hit", 64'(rd_hit), 64'd0);

    // write entry 3 while reading it in the same cycle
    set_wr(0, 3, 32'hDEADBEEF, 4'b0000);
    set_rd(0, 3);
    tick();
    idle();
`ifdef VB_BYPASS_EN
    check_eq("same_cycle_hit", 64'(rd_hit[0]), 64'd1);
    check_eq("same_cycle_val", 64'(rv(0)), 64'hDEADBEEF);
`else
    check_eq("same_cycle_hit", 64'(rd_hit[0]), 64'd0);
`endif
    check_eq("wr3_occ", 64'(occupancy), 64'd1);
    set_rd(0, 3);
    tick();
    check_eq("rd3_val", 64'(rv(0)), 64'hDEADBEEF);
    check_eq("rd3_hit", 64'(rd_hit[0]), 64'd1);

    // stalled write must not land
    idle();
    stall = 1'b1;
    set_wr(0, 5, 32'h12345678, 4'b0000);
    tick();
    idle();
    check_eq("stall_occ", 64'(occupancy), 64'd1);
    set_rd(1, 5);
    tick();
    check_eq("stall_hit", 64'(rd_hit[1]), 64'd0);

    // both ports target entry 7, port 1 wins
    idle();
    set_wr(0, 7, 32'h11, 4'b0000);
    set_wr(1, 7, 32'h22, 4'b0000);
    tick();
    idle();
    check_eq("conflict_occ", 64'(occupancy), 64'd2);
    set_rd(2, 7);
    tick();
    check_eq("conflict_val", 64'(rv(2)), 64'h22);
    check_eq("conflict_hit", 64'(rd_hit[2]), 64'd1);

    // kill tag 0001: entries 1 and 4 squash, entry 2 survives
    idle();
    set_wr(0, 1, 32'hA1, 4'b0001);
    set_wr(1, 2, 32'hA2, 4'b0010);
    tick();
    idle();
    set_wr(0, 4, 32'hA4, 4'b0011);
    tick();
    idle();
    check_eq("prekill_occ", 64'(occupancy), 64'd5);
    br_kill = 1'b1; br_kill_tag = 4'b0001;
    set_wr(0, 10, 32'hB0, 4'b0001);
    set_wr(1, 11, 32'hB1, 4'b0010);
    tick();
    idle();
    check_eq("kill_occ", 64'(occupancy), 64'd4);
    set_rd(0, 1); set_rd(1, 2); set_rd(2, 4);
    tick();
    check_eq("kill_hit1", 64'(rd_hit[0]), 64'd0);
    check_eq("kill_hit2", 64'(rd_hit[1]), 64'd1);
    check_eq("kill_hit4", 64'(rd_hit[2]), 64'd0);
    idle();
    set_rd(0, 10); set_rd(1, 11);
    tick();
    check_eq("kill_drop10", 64'(rd_hit[0]), 64'd0);
    check_eq("kill_keep11", 64'(rd_hit[1]), 64'd1);
    check_eq("kill_val11", 64'(rv(1)), 64'hB1);

    // confirm tag 0100 then kill it: entry 9 and same-cycle-written entry 13 survive
    idle();
    set_wr(0, 9, 32'hC9, 4'b0100);
    tick();
    idle();
    br_ok = 1'b1; br_ok_tag = 4'b0100;
    set_wr(0, 13, 32'hCD, 4'b0100);
    tick();
    idle();
    check_eq("ok_occ", 64'(occupancy), 64'd6);
    br_kill = 1'b1; br_kill_tag = 4'b0100;
    tick();
    idle();
    check_eq("ok_kill_occ", 64'(occupancy), 64'd6);
    set_rd(0, 9); set_rd(1, 13);
    tick();
    check_eq("ok_hit9", 64'(rd_hit[0]), 64'd1);
    check_eq("ok_hit13", 64'(rd_hit[1]), 64'd1);

    // ok and kill on one tag in one cycle: kill wins
    idle();
    set_wr(0, 12, 32'hCC, 4'b1000);
    tick();
    idle();
    check_eq("wr12_occ", 64'(occupancy), 64'd7);
    br_ok = 1'b1; br_ok_tag = 4'b1000;
    br_kill = 1'b1; br_kill_tag = 4'b1000;
    tick();
    idle();
    check_eq("okkill_occ", 64'(occupancy), 64'd6);
    set_rd(0, 12);
    tick();
    check_eq("okkill_hit12", 64'(rd_hit[0]), 64'd0);

    // release and write entry 6 together: write wins
    idle();
    set_rel(0, 6);
    set_wr(0, 6, 32'h55, 4'b0000);
    set_rd(2, 6);
    tick();
    idle();
    check_eq("relwr_occ", 64'(occupancy), 64'd7);
`ifdef VB_BYPASS_EN
    check_eq("bypass_val", 64'(rv(2)), 64'h55);
    check_eq("bypass_hit", 64'(rd_hit[2]), 64'd1);
`else
    check_eq("nobypass_hit", 64'(rd_hit[2]), 64'd0);
`endif
    set_rd(2, 6);
    tick();
    check_eq("relwr_val", 64'(rv(2)), 64'h55);
    check_eq("relwr_hit", 64'(rd_hit[2]), 64'd1);

    // plain release of entry 3
    idle();
    set_rel(1, 3);
    tick();
    idle();
    check_eq("rel_occ", 64'(occupancy), 64'd6);
    set_rd(0, 3);
    tick();
    check_eq("rel_hit3", 64'(rd_hit[0]), 64'd0);

    // reset overrides a write; payload survives reset but valid does not
    idle();
    reset = 1'b0;
    set_wr(0, 20, 32'hEE, 4'b0000);
    tick();
    idle();
    reset = 1'b1;
    check_eq("reset2_occ", 64'(occupancy), 64'd0);
    check_eq("reset2_val", 64'(rd_value), 64'd0);
    set_rd(0, 6); set_rd(1, 20);
    tick();
    check_eq("reset2_hit", 64'(rd_hit), 64'd0);
    check_eq("reset2_data6", 64'(rv(0)), 64'h55);
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
